// File: rtl/iob_axi_pkg.sv
// Shared AXI encodings and responder FSM states.
package iob_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WDATA = 2'b01,
        ST_WRESP = 2'b10,
        ST_RDATA = 2'b11
    } state_e;

    // Narrow requests are fine, but anything wider than the bus collapses to full width.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
module iob_ram_sp_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   d_i,
    output logic [DATA_W-1:0]   d_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] d_q;

    // NOTE: the array has no reset on purpose; contents must survive a reset and stay RAM-mappable.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (en_i && we_i[b]) begin
                mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
            end
        end
    end

    // The read register only updates on a read, so it doubles as the R-channel holding register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            d_q <= '0;
        end else if (en_i && (we_i == '0)) begin
            d_q <= mem[addr_i];
        end
    end

    assign d_o = d_q;

endmodule

// File: rtl/iob_axi_ram_responder.sv
// AXI4 slave over on-chip RAM: INCR/FIXED bursts, one outstanding transaction.
module iob_axi_ram_responder
    import iob_axi_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 4,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic [1:0]              axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [2:0]              axi_awprot_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic [1:0]              axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [2:0]              axi_arprot_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int STRB_W  = AXI_DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int BADDR_W = MEM_ADDR_W + OFF_W;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    state_e                state_q, state_d;
    logic                  prio_rd_q, prio_rd_d;
    logic                  awready_q, awready_d;
    logic                  arready_q, arready_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [BADDR_W-1:0]    addr_q, addr_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [AXI_LEN_W-1:0]  beat_q, beat_d;
    logic [2:0]            size_q, size_d;
    logic                  fixed_q, fixed_d;
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;

    logic                  ram_en;
    logic [STRB_W-1:0]     ram_we;
    logic [AXI_DATA_W-1:0] ram_dout;
    logic [BADDR_W-1:0]    next_addr;
    logic                  last_beat;
    logic                  r_drain;
    logic                  unused_ok;

    assign next_addr = fixed_q ? addr_q : addr_q + (BADDR_W'(1) << size_q);
    assign last_beat = (beat_q == len_q);
    assign r_drain   = rvalid_q && axi_rready_i;

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        fixed_d   = fixed_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        ram_en    = 1'b0;
        ram_we    = '0;

        case (state_q)
            ST_IDLE: begin
                if (axi_awvalid_i && awready_q) begin
                    id_d      = axi_awid_i;
                    addr_d    = axi_awaddr_i[BADDR_W-1:0];
                    len_d     = axi_awlen_i;
                    size_d    = clamp_size(axi_awsize_i, MAX_SIZE);
                    fixed_d   = (axi_awburst_i == BURST_FIXED);
                    beat_d    = '0;
                    err_d     = 1'b0;
                    prio_rd_d = 1'b1;
                    state_d   = ST_WDATA;
                end else if (axi_arvalid_i && arready_q) begin
                    id_d      = axi_arid_i;
                    addr_d    = axi_araddr_i[BADDR_W-1:0];
                    len_d     = axi_arlen_i;
                    size_d    = clamp_size(axi_arsize_i, MAX_SIZE);
                    fixed_d   = (axi_arburst_i == BURST_FIXED);
                    beat_d    = '0;
                    prio_rd_d = 1'b0;
                    state_d   = ST_RDATA;
                end else if (!awready_q && !arready_q) begin
                    // Ready is a registered one-cycle pulse granted to the arbitration winner.
                    if (axi_awvalid_i && (!axi_arvalid_i || !prio_rd_q)) begin
                        awready_d = 1'b1;
                    end else if (axi_arvalid_i) begin
                        arready_d = 1'b1;
                    end
                end
            end

            ST_WDATA: begin
                if (axi_wvalid_i) begin
                    ram_en = 1'b1;
                    ram_we = axi_wstrb_i;
                    addr_d = next_addr;
                    if (axi_wlast_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_WRESP;
                    end else begin
                        beat_d = beat_q + AXI_LEN_W'(1);
                    end
                end
            end

            ST_WRESP: begin
                if (axi_bready_i) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RDATA: begin
                if (r_drain) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end
                end
                // Issue the next read only while the output register is empty or draining.
                if (!(rvalid_q && rlast_q) && (!rvalid_q || axi_rready_i)) begin
                    ram_en   = 1'b1;
                    addr_d   = next_addr;
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    beat_d   = beat_q + AXI_LEN_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            prio_rd_q <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            fixed_q   <= fixed_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    iob_ram_sp_be #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (addr_q[BADDR_W-1:OFF_W]),
        .d_i    (axi_wdata_i),
        .d_o    (ram_dout)
    );

    assign axi_awready_o = awready_q;
    assign axi_arready_o = arready_q;
    assign axi_wready_o  = (state_q == ST_WDATA);
    assign axi_bvalid_o  = (state_q == ST_WRESP);
    assign axi_bid_o     = id_q;
    assign axi_bresp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid_o     = id_q;
    assign axi_rdata_o   = ram_dout;
    assign axi_rresp_o   = RESP_OKAY;
    assign axi_rlast_o   = rlast_q;
    assign axi_rvalid_o  = rvalid_q;

    assign unused_ok = ^{axi_awlock_i, axi_awcache_i, axi_awprot_i,
                         axi_arlock_i, axi_arcache_i, axi_arprot_i,
                         axi_awaddr_i[AXI_ADDR_W-1:BADDR_W],
                         axi_araddr_i[AXI_ADDR_W-1:BADDR_W]};

endmodule
